// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {PORT_I, PORT_D} arb_port_t;
  localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: fetch, load/store and memory-side signals of the arbiter.
interface mem_arb_if #(parameter int ADDR_W = 12);
  logic              i_req_valid;
  logic              i_req_ready;
  logic [31:0]       i_addr;
  logic              i_resp_valid;
  logic [31:0]       i_rdata;
  logic              d_req_valid;
  logic              d_req_ready;
  logic [31:0]       d_addr;
  logic              d_we;
  logic [3:0]        d_be;
  logic [31:0]       d_wdata;
  logic              d_resp_valid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport slave (
    input  i_req_valid, i_addr, d_req_valid, d_addr, d_we, d_be, d_wdata, mem_rdata,
    output i_req_ready, i_resp_valid, i_rdata, d_req_ready, d_resp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport master (
    output i_req_valid, i_addr, d_req_valid, d_addr, d_we, d_be, d_wdata, mem_rdata,
    input  i_req_ready, i_resp_valid, i_rdata, d_req_ready, d_resp_valid, d_rdata,
           mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; round-robin when MEM_ARBITER_RR_EN is defined, else D over I.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic      i_valid,
  input  logic      d_valid,
`ifdef MEM_ARBITER_RR_EN
  input  arb_port_t last,
`endif
  output arb_port_t win
);
  arb_port_t tie;
`ifdef MEM_ARBITER_RR_EN
  assign tie = (last == PORT_D) ? PORT_I : PORT_D;
`else
  assign tie = PORT_D;
`endif
  always_comb win = (i_valid && d_valid) ? tie : (d_valid ? PORT_D : PORT_I);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (I) and load/store (D), one access in flight.
// Define MEM_ARBITER_RR_EN for round-robin priority instead of fixed D-over-I.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 1
) (
  input logic      clk,
  input logic      reset,
  mem_arb_if.slave bus
);
  localparam int CW = $clog2(MEM_LAT + 1);
  arb_state_t     state;
  arb_port_t      gnt;
  arb_port_t      win;
  logic           store;
  logic           hs;
  logic           pick_d;
  logic [31:0]    addr_sel;
  logic [CW-1:0]  cnt;
`ifdef MEM_ARBITER_RR_EN
  arb_port_t last;
  always_ff @(posedge clk)
    if (reset) last <= PORT_I;
    else if (hs) last <= win;
`endif
  mem_arb_pick pick (
    .i_valid(bus.i_req_valid),
    .d_valid(bus.d_req_valid),
`ifdef MEM_ARBITER_RR_EN
    .last(last),
`endif
    .win(win)
  );
  // Ready is gated by reset so nothing is accepted until the cycle after reset drops.
  always_comb begin
    bus.i_req_ready = !reset && state == IDLE && bus.i_req_valid && win == PORT_I;
    bus.d_req_ready = !reset && state == IDLE && bus.d_req_valid && win == PORT_D;
    hs = bus.i_req_ready || bus.d_req_ready;
    pick_d = win == PORT_D;
    addr_sel = pick_d ? bus.d_addr : bus.i_addr;
    bus.i_rdata = bus.i_resp_valid ? bus.mem_rdata : '0;
    bus.d_rdata = (bus.d_resp_valid && !store) ? bus.mem_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt <= PORT_I;
      store <= 1'b0;
      cnt <= '0;
      bus.i_resp_valid <= 1'b0;
      bus.d_resp_valid <= 1'b0;
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_be <= '0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.i_resp_valid <= 1'b0;
      bus.d_resp_valid <= 1'b0;
      case (state)
        IDLE: if (hs) begin
          state <= ISSUE;
          gnt <= win;
          store <= pick_d && bus.d_we;
          bus.mem_en <= 1'b1;
          bus.mem_we <= pick_d && bus.d_we;
          bus.mem_be <= pick_d ? bus.d_be : BE_FULL;
          bus.mem_addr <= addr_sel[ADDR_W+1:2];
          bus.mem_wdata <= pick_d ? bus.d_wdata : '0;
        end
        ISSUE: begin
          state <= (MEM_LAT == 1) ? RESP : WAIT;
          cnt <= CW'(MEM_LAT - 2);
          bus.i_resp_valid <= MEM_LAT == 1 && gnt == PORT_I;
          bus.d_resp_valid <= MEM_LAT == 1 && gnt == PORT_D;
        end
        WAIT: if (cnt == '0) begin
          state <= RESP;
          bus.i_resp_valid <= gnt == PORT_I;
          bus.d_resp_valid <= gnt == PORT_D;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random requests on both ports for MEM_LAT=1 and MEM_LAT=3, checked against a transaction-level model.
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int ADDR_W = 12;
  localparam int NCYC = 2000;
`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  bit done [2];
  task automatic check(string tag, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", tag, got, want);
    end
  endtask
  function automatic logic [31:0] fill(int w);
    return (32'h9E3779B9 * (w + 1)) ^ 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b+:8] = wd[8*b+:8];
    return r;
  endfunction
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g ? 3 : 1;
    logic reset;
    mem_arb_if #(.ADDR_W(ADDR_W)) bus ();
    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));
    logic [31:0] dmem [4096];
    bit          wr   [4096];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
      if (bus.mem_en) begin
        pipe[0] <= wr[bus.mem_addr] ? dmem[bus.mem_addr] : fill(int'(bus.mem_addr));
        if (bus.mem_we) begin
          dmem[bus.mem_addr] <= merge(wr[bus.mem_addr] ? dmem[bus.mem_addr] : fill(int'(bus.mem_addr)),
                                      bus.mem_wdata, bus.mem_be);
          wr[bus.mem_addr] <= 1'b1;
        end
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];
    logic [31:0] ref_mem [16];
    initial begin
      int free_at, iss_cyc, rsp_cyc, w;
      arb_port_t last, rsp_port, tie, win;
      logic [31:0] rsp_data, r, wd;
      logic [11:0] iss_w;
      logic [3:0]  iss_be;
      logic iss_we, post_rst, idle, ei, ed, en, ri, rd, acc_i, acc_d;
      for (int k = 0; k < 16; k++) ref_mem[k] = fill(k);
      reset = 1'b1;
      bus.i_req_valid = 1'b0; bus.i_addr = '0;
      bus.d_req_valid = 1'b0; bus.d_addr = '0; bus.d_we = 1'b0; bus.d_be = '0; bus.d_wdata = '0;
      free_at = 0; iss_cyc = -1; rsp_cyc = -1; last = PORT_I; rsp_port = PORT_I; rsp_data = '0;
      iss_w = '0; iss_be = '0; iss_we = 1'b0; wd = '0; post_rst = 1'b0; acc_i = 1'b0; acc_d = 1'b0;
      for (int c = 0; c < NCYC; c++) begin
        @(posedge clk); #1;
        reset = (c < 3) || ($urandom_range(0, 59) == 0);
        if (acc_i) begin bus.i_req_valid = 1'b0; acc_i = 1'b0; end
        if (acc_d) begin bus.d_req_valid = 1'b0; acc_d = 1'b0; end
        if (!bus.i_req_valid && $urandom_range(0, 2) != 0) begin
          r = $urandom();
          bus.i_req_valid = 1'b1;
          bus.i_addr = {r[31:14], 12'($urandom_range(0, 15)), r[1:0]};
        end
        if (!bus.d_req_valid && $urandom_range(0, 2) != 0) begin
          r = $urandom();
          bus.d_req_valid = 1'b1;
          bus.d_addr = {r[31:14], 12'($urandom_range(0, 15)), r[1:0]};
          bus.d_we = r[2];
          bus.d_be = 4'($urandom());
          bus.d_wdata = $urandom();
        end
        @(negedge clk);
        idle = !reset && c >= free_at;
        tie = (RR && last == PORT_D) ? PORT_I : PORT_D;
        win = (bus.i_req_valid && bus.d_req_valid) ? tie : (bus.d_req_valid ? PORT_D : PORT_I);
        ei = idle && bus.i_req_valid && win == PORT_I;
        ed = idle && bus.d_req_valid && win == PORT_D;
        en = c == iss_cyc;
        ri = c == rsp_cyc && rsp_port == PORT_I;
        rd = c == rsp_cyc && rsp_port == PORT_D;
        if (c >= 1) begin
          check("i_req_ready", bus.i_req_ready, ei);
          check("d_req_ready", bus.d_req_ready, ed);
          check("mem_en", bus.mem_en, en);
          check("i_resp_valid", bus.i_resp_valid, ri);
          check("d_resp_valid", bus.d_resp_valid, rd);
          check("i_rdata", bus.i_rdata, ri ? rsp_data : 32'h0);
          check("d_rdata", bus.d_rdata, rd ? rsp_data : 32'h0);
          if (en) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(iss_w));
            check("mem_be", 32'(bus.mem_be), 32'(iss_be));
            check("mem_we", bus.mem_we, iss_we);
            if (iss_we) check("mem_wdata", bus.mem_wdata, wd);
          end
          if (post_rst) begin
            check("rst mem_we", bus.mem_we, 1'b0);
            check("rst mem_be", 32'(bus.mem_be), 32'h0);
            check("rst mem_addr", 32'(bus.mem_addr), 32'h0);
            check("rst mem_wdata", bus.mem_wdata, 32'h0);
          end
        end
        post_rst = reset;
        if (reset) begin
          if (rsp_cyc > c) rsp_cyc = -1;
          free_at = c + 1;
          last = PORT_I;
        end else if (ei || ed) begin
          r = ed ? bus.d_addr : bus.i_addr;
          iss_w = r[13:2];
          w = int'(r[5:2]);
          iss_we = ed && bus.d_we;
          iss_be = ed ? bus.d_be : 4'hF;
          wd = bus.d_wdata;
          rsp_port = ed ? PORT_D : PORT_I;
          rsp_data = iss_we ? 32'h0 : ref_mem[w];
          if (iss_we) ref_mem[w] = merge(ref_mem[w], wd, iss_be);
          iss_cyc = c + 1;
          rsp_cyc = c + 1 + LAT;
          free_at = c + 2 + LAT;
          last = rsp_port;
          acc_i = ei;
          acc_d = ed;
        end
      end
      done[g] = 1'b1;
    end
  end
  initial begin
    fork
      wait (done[0] && done[1]);
      repeat (NCYC * 4) @(posedge clk);
    join_any
    disable fork;
    check("run completes", {31'h0, done[0] && done[1]}, 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
